// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs; clear beats push.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~clear;
   assign do_push = push & ~clear & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= ptr_inc(wptr);
         if (do_pop)  rptr <= ptr_inc(rptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation, credit-limited imem requests, wrong-path drop and IF/ID register.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemGnt,
   input  logic        IMemRValid,
   input  logic [31:0] IMemRData,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pcf_q, pcf_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [CW:0]   inflight;
   logic          grant;
   logic          dropping;
   logic [CW-1:0] live;
   logic [31:0]   rsp_pc;

   fetch_entry_t  buf_wdata;
   fetch_entry_t  buf_head;
   logic          buf_push;
   logic          buf_pop;
   logic          buf_full;
   logic          buf_empty;
   logic [CW-1:0] buf_count;

   // Credit counts both in-flight and buffered words so the buffer can never overflow.
   assign inflight = {1'b0, out_q} + {1'b0, buf_count};
   assign IMemReq  = (state_q != BOOT) & ~StallF & ~PCSrcE & (32'(inflight) < DEPTH);
   assign IMemAddr = pcf_q;
   assign grant    = IMemReq & IMemGnt;
   assign dropping = (drop_q != '0);

   // Live requests were issued back-to-back since the last redirect, ending at PCF-4.
   assign live   = out_q - drop_q;
   assign rsp_pc = pcf_q - (32'(live) << 2);

   assign buf_wdata.instr = IMemRData;
   assign buf_wdata.pc    = rsp_pc;
   assign buf_push        = IMemRValid & ~dropping & ~PCSrcE;
   assign buf_pop         = ~StallD & ~FlushD & ~buf_empty;

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk   (clk),
      .rst   (rst),
      .push  (buf_push),
      .pop   (buf_pop),
      .clear (PCSrcE),
      .wdata (buf_wdata),
      .rdata (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pcf_q   <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pcf_q   <= pcf_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pcf_d   = pcf_q;
      out_d   = out_q + CW'(grant) - CW'(IMemRValid);
      drop_d  = drop_q;

      if (PCSrcE) begin
         pcf_d  = PCTargetE;
         drop_d = out_q - CW'(IMemRValid);
      end else begin
         if (grant) pcf_d = pcf_q + 32'd4;
         if (IMemRValid && dropping) drop_d = drop_q - CW'(1);
      end

      case (state_q)
         BOOT:       state_d = RUN;
         RUN, DRAIN: state_d = (drop_d != '0) ? DRAIN : RUN;
         default:    state_d = BOOT;
      endcase
   end

   // IF/ID pipeline register; a flush bubbles without disturbing the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
      end else if (!StallD) begin
         if (!FlushD && !buf_empty) begin
            InstrD   <= buf_head.instr;
            PCD      <= buf_head.pc;
            PCPlus4D <= buf_head.pc + 32'd4;
         end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the fetch rules.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt, IMemRValid;
   logic [31:0] IMemRData;
   logic [31:0] InstrD, PCD, PCPlus4D;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .DEPTH     (DEPTH),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemGnt    (IMemGnt),
      .IMemRValid (IMemRValid),
      .IMemRData  (IMemRData),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t mem_q[$];
   int    last_due = 0;
   int    cyc      = 0;
   bit    directed = 1'b1;
   int    errors   = 0;
   int    checks   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model state
   logic [31:0]  m_pcf;
   int           m_out, m_drop;
   bit           m_boot;
   fetch_entry_t bq[$];
   logic [31:0]  live_q[$];
   logic [31:0]  m_instr, m_pcd, m_pcp4;
   bit           armed = 1'b0;
   int           k     = -1;

   // Compare and model-advance at the falling edge, when all inputs are settled.
   initial begin
      forever begin
         bit           exp_req;
         bit           grant;
         fetch_entry_t e;
         logic [31:0]  rpc;
         int           lat;
         @(negedge clk);
         exp_req = !m_boot && !StallF && !PCSrcE && ((m_out + bq.size()) < DEPTH);
         if (armed) begin
            chk("imem_req", 32'(IMemReq), 32'(exp_req));
            if (exp_req) chk("imem_addr", IMemAddr, m_pcf);
            chk("instr_d", InstrD, m_instr);
            chk("pc_d", PCD, m_pcd);
            chk("pc_plus4_d", PCPlus4D, m_pcp4);
            if (directed && !rst) begin
               case (k)
                  0: begin chk("pin_k0_req", 32'(IMemReq), 32'd0);
                           chk("pin_k0_instr", InstrD, 32'h0000_0013);
                           chk("pin_k0_pcd", PCD, 32'h0); end
                  1: begin chk("pin_k1_req", 32'(IMemReq), 32'd1);
                           chk("pin_k1_addr", IMemAddr, 32'h0); end
                  2: chk("pin_k2_addr", IMemAddr, 32'h4);
                  3: begin chk("pin_k3_req", 32'(IMemReq), 32'd0);
                           chk("pin_k3_instr", InstrD, 32'h0000_0013); end
                  4: begin chk("pin_k4_addr", IMemAddr, 32'h8);
                           chk("pin_k4_instr", InstrD, 32'h1234_5013);
                           chk("pin_k4_pcd", PCD, 32'h0);
                           chk("pin_k4_pcp4", PCPlus4D, 32'h4); end
                  5: begin chk("pin_k5_instr", InstrD, 32'h1230_5013);
                           chk("pin_k5_pcd", PCD, 32'h4); end
                  default: ;
               endcase
            end
         end

         // Memory side: log accepted requests with in-order due cycles.
         if (rst) begin
            mem_q.delete();
            last_due = cyc;
         end else if (IMemReq && IMemGnt) begin
            lat = directed ? 1 : int'($urandom_range(1, 3));
            if (cyc + lat <= last_due) last_due = last_due + 1;
            else last_due = cyc + lat;
            mem_q.push_back('{addr: IMemAddr, due: last_due});
         end

         if (rst) begin
            m_pcf   = 32'h0;
            m_out   = 0;
            m_drop  = 0;
            m_boot  = 1'b1;
            bq.delete();
            live_q.delete();
            m_instr = 32'h0000_0013;
            m_pcd   = 32'h0;
            m_pcp4  = 32'h0;
            armed   = 1'b1;
            k       = 0;
         end else if (armed) begin
            grant = exp_req && IMemGnt;
            if (!StallD) begin
               if (!FlushD && bq.size() > 0) begin
                  e       = bq.pop_front();
                  m_instr = e.instr;
                  m_pcd   = e.pc;
                  m_pcp4  = e.pc + 32'd4;
               end else begin
                  m_instr = 32'h0000_0013;
                  m_pcd   = 32'h0;
                  m_pcp4  = 32'h0;
               end
            end
            if (IMemRValid) begin
               m_out--;
               if (m_drop > 0) m_drop--;
               else if (live_q.size() > 0) begin
                  rpc = live_q.pop_front();
                  if (!PCSrcE) begin
                     e.instr = IMemRData;
                     e.pc    = rpc;
                     bq.push_back(e);
                  end
               end
            end
            if (PCSrcE) begin
               m_drop = m_out;
               live_q.delete();
               bq.delete();
               m_pcf = PCTargetE;
            end else if (grant) begin
               live_q.push_back(m_pcf);
               m_out++;
               m_pcf = m_pcf + 32'd4;
            end
            m_boot = 1'b0;
            k++;
         end
      end
   end

   task automatic drive_mem();
      if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         IMemRValid = 1'b1;
         IMemRData  = mem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         IMemRValid = 1'b0;
         IMemRData  = $urandom;
      end
   endtask

   task automatic step(input bit r, input bit rnd);
      @(posedge clk);
      #1;
      cyc++;
      rst = r;
      if (rnd) begin
         PCSrcE    = ($urandom_range(0, 99) < 6);
         FlushD    = PCSrcE || ($urandom_range(0, 99) < 8);
         StallD    = !FlushD && ($urandom_range(0, 99) < 25);
         StallF    = ($urandom_range(0, 99) < 15);
         IMemGnt   = ($urandom_range(0, 99) < 70);
         PCTargetE = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : {$urandom_range(0, 32'h3FFF), 2'b00};
      end else begin
         PCSrcE    = 1'b0;
         FlushD    = 1'b0;
         StallD    = 1'b0;
         StallF    = 1'b0;
         IMemGnt   = 1'b1;
         PCTargetE = 32'h0;
      end
      drive_mem();
   endtask

   initial begin
      rst        = 1'b1;
      StallF     = 1'b0;
      StallD     = 1'b0;
      FlushD     = 1'b0;
      PCSrcE     = 1'b0;
      PCTargetE  = 32'h0;
      IMemGnt    = 1'b1;
      IMemRValid = 1'b0;
      IMemRData  = 32'h0;
      repeat (2) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      directed = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i >= 1500 && i < 1502) step(1'b1, 1'b1);
         else step(1'b0, 1'b1);
      end
      repeat (20) step(1'b0, 1'b0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
